// File: rtl/usb_pkg.sv
// Shared definitions for the USB transfer engine.
//  - TX FSM state encoding (plain localparams, legacy-compatible)
//  - CCR / STA bit indices and default register byte addresses
//  - byte_sel(): picks byte idx (0 = LSB) out of a 32-bit word
package usb_pkg;

  // Control register (CCR) bit indices
  localparam int CCR_EN = 0;
  localparam int CCR_TX = 1;
  localparam int CCR_RX = 2;

  // Status (STA) bit indices
  localparam int STA_TX_BUSY  = 0;
  localparam int STA_RX_VALID = 1;

  // Register byte addresses on the peripheral ports
  localparam logic [31:0] TX_ADDR_DEF = 32'h8;  // TXDATA, reg 2
  localparam logic [31:0] RX_ADDR_DEF = 32'h4;  // RXDATA, reg 1

  // TX FSM states
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_LOAD = 2'd1;
  localparam logic [1:0] T_SEND = 2'd2;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/usb_rx_packer.sv
// Packs four received bytes (first byte in the LSB) into one 32-bit word.
// Ports:
//  clk_i, rst_i   clock, synchronous active-high reset
//  clr_i          engine disabled: drop any partial word
//  rx_en_i        receive enabled (CCR enable & rx enable)
//  rx_full_i      previous word not yet acknowledged
//  rx_data_i/rx_valid_i/rx_ready_o   byte stream handshake
//  wr_pend_o      one-cycle flag: word complete, write it this cycle
//  word_o         packed word
module usb_rx_packer
  import usb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        rx_en_i,
  input  logic        rx_full_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        wr_pend_o,
  output logic [31:0] word_o
);

  logic [1:0]  rcnt_q;
  logic [31:0] rx_sh_q;
  logic        wr_pend_q;
  logic        rx_hs;

  // Backpressure rather than overrun: stall while a word is waiting or unacknowledged.
  assign rx_ready_o = rx_en_i & ~rx_full_i & ~wr_pend_q;
  assign rx_hs      = rx_valid_i & rx_ready_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q    <= 2'd0;
      rx_sh_q   <= 32'd0;
      wr_pend_q <= 1'b0;
    end else begin
      // Pending lasts exactly one cycle: no byte can be taken while it is set.
      wr_pend_q <= rx_hs & (rcnt_q == 2'd3);
      if (clr_i) begin
        rcnt_q <= 2'd0;
      end else if (rx_hs) begin
        rx_sh_q[{rcnt_q, 3'b000} +: 8] <= rx_data_i;
        rcnt_q                         <= rcnt_q + 2'd1;  // wraps to 0 after byte 3
      end
    end
  end

  assign wr_pend_o = wr_pend_q;
  assign word_o    = rx_sh_q;

endmodule

// File: rtl/usb_xfer_engine.sv
// Peripheral-side USB transfer engine.
//  TX: on a start edge, reads TXDATA and streams it out LSB byte first.
//  RX: packs four bytes into a word and writes it to RXDATA, then holds
//      off further bytes until firmware acknowledges via status bit 1.
// Ports:
//  clk_i, rst_i                 clock, synchronous active-high reset
//  usb_ccr_nxt_i[2:0]           CCR next value {rx en, tx start, enable}
//  usb_sta_1_i                  status bit 1 as held in reg 3
//  usb_sta_o[1:0]               {rx word valid, tx busy}
//  rdaddr_perip / data_o_perip  TXDATA read port
//  write_perip / wraddr_perip / data_i_perip   RXDATA write port
//  tx_data_o/tx_valid_o/tx_ready_i             outgoing byte stream
//  rx_data_i/rx_valid_i/rx_ready_o             incoming byte stream
module usb_xfer_engine
  import usb_pkg::*;
#(
  parameter logic [31:0] TX_ADDR = TX_ADDR_DEF,
  parameter logic [31:0] RX_ADDR = RX_ADDR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  usb_ccr_nxt_i,
  input  logic        usb_sta_1_i,
  output logic [1:0]  usb_sta_o,
  output logic [31:0] rdaddr_perip,
  input  logic [31:0] data_o_perip,
  output logic        write_perip,
  output logic [31:0] wraddr_perip,
  output logic [31:0] data_i_perip,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  logic [2:0]  ccr_q;
  logic        start_q;
  logic        start_pulse;
  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic        tx_hs;
  logic        rx_full_q, rx_full_d;
  logic        rx_full_dly_q;
  logic        wr_pend;

  // Edge-detect on the start bit: a held bit runs one transfer only.
  assign start_pulse = ccr_q[CCR_EN] & ccr_q[CCR_TX] & ~start_q;

  // Gating with enable drops valid in the same cycle the disable is seen.
  assign tx_valid_o = (state_q == T_SEND) & ccr_q[CCR_EN];
  assign tx_hs      = tx_valid_o & tx_ready_i;
  assign tx_data_o  = byte_sel(tx_sh_q, cnt_q);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_sh_d = tx_sh_q;
    case (state_q)
      T_IDLE: if (start_pulse) state_d = T_LOAD;
      T_LOAD: begin
        tx_sh_d = data_o_perip;
        cnt_d   = 2'd0;
        state_d = T_SEND;
      end
      T_SEND: if (tx_hs) begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
    // Disable aborts any transfer in progress.
    if (!ccr_q[CCR_EN]) state_d = T_IDLE;
  end

  // rx_full sets on the RXDATA write; the clear requires rx_full to have been
  // set for a cycle already so the stale reg 3 echo cannot clear it.
  always_comb begin
    rx_full_d = rx_full_q;
    if (wr_pend)                                      rx_full_d = 1'b1;
    else if (rx_full_q & rx_full_dly_q & ~usb_sta_1_i) rx_full_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ccr_q         <= 3'd0;
      start_q       <= 1'b0;
      state_q       <= T_IDLE;
      cnt_q         <= 2'd0;
      tx_sh_q       <= 32'd0;
      rx_full_q     <= 1'b0;
      rx_full_dly_q <= 1'b0;
    end else begin
      ccr_q         <= usb_ccr_nxt_i;
      start_q       <= ccr_q[CCR_TX];
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_sh_q       <= tx_sh_d;
      rx_full_q     <= rx_full_d;
      rx_full_dly_q <= rx_full_q;
    end
  end

  usb_rx_packer u_rx_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (~ccr_q[CCR_EN]),
    .rx_en_i    (ccr_q[CCR_EN] & ccr_q[CCR_RX]),
    .rx_full_i  (rx_full_q),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .wr_pend_o  (wr_pend),
    .word_o     (data_i_perip)
  );

  assign write_perip              = wr_pend;
  assign rdaddr_perip             = TX_ADDR;
  assign wraddr_perip             = RX_ADDR;
  assign usb_sta_o[STA_TX_BUSY]   = (state_q != T_IDLE);
  assign usb_sta_o[STA_RX_VALID]  = rx_full_q;

endmodule

// File: tb/tb_usb_xfer_engine.sv
// Self-checking bench for usb_xfer_engine: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based transfer model.
module tb_usb_xfer_engine;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  usb_ccr_nxt_i;
  logic        usb_sta_1_i;
  logic [1:0]  usb_sta_o;
  logic [31:0] rdaddr_perip;
  logic [31:0] data_o_perip;
  logic        write_perip;
  logic [31:0] wraddr_perip;
  logic [31:0] data_i_perip;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;

  usb_xfer_engine dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .usb_ccr_nxt_i (usb_ccr_nxt_i),
    .usb_sta_1_i   (usb_sta_1_i),
    .usb_sta_o     (usb_sta_o),
    .rdaddr_perip  (rdaddr_perip),
    .data_o_perip  (data_o_perip),
    .write_perip   (write_perip),
    .wraddr_perip  (wraddr_perip),
    .data_i_perip  (data_i_perip),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .rx_ready_o    (rx_ready_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // TX is a queue of bytes still owed to the stream; RX is a queue of bytes
  // gathered toward the next word.
  logic [2:0]  m_ccr = '0;     // CCR as seen by the engine (one cycle late)
  bit          m_start_prev;
  bit          m_loading;      // cycle in which TXDATA is captured
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_wrpend;
  logic [31:0] m_word;
  bit          m_full, m_full_d;
  bit          env_reg3;       // reg 3 bit 1 in the register block
  bit          fw_ack;         // firmware writes reg 3 bit 1 = 0 this cycle
  bit          chk_on = 0;

  always @(posedge clk) begin : model_step
    logic [2:0] ccr_old;
    bit full_old, wrpend_old, hs;
    ccr_old    = m_ccr;
    full_old   = m_full;
    wrpend_old = m_wrpend;
    if (rst_i) begin
      m_ccr = '0; m_start_prev = 0; m_loading = 0; txq.delete(); rxq.delete();
      m_wrpend = 0; m_full = 0; m_full_d = 0; env_reg3 = 0;
    end else begin
      // TX
      if (!ccr_old[0]) begin
        m_loading = 0;
        txq.delete();
      end else if (m_loading) begin
        m_loading = 0;
        for (int b = 0; b < 4; b++) txq.push_back(data_o_perip[8*b +: 8]);
      end else if (txq.size() != 0) begin
        if (tx_ready_i) void'(txq.pop_front());
      end else if (ccr_old[1] && !m_start_prev) begin
        m_loading = 1;
      end
      // RX
      hs = rx_valid_i && ccr_old[0] && ccr_old[2] && !full_old && !wrpend_old;
      env_reg3 = fw_ack ? 1'b0 : full_old;
      if (wrpend_old)                          m_full = 1;
      else if (full_old && m_full_d && !usb_sta_1_i) m_full = 0;
      m_full_d = full_old;
      m_wrpend = 0;
      if (!ccr_old[0]) rxq.delete();
      else if (hs) begin
        rxq.push_back(rx_data_i);
        if (rxq.size() == 4) begin
          m_word   = {rxq[3], rxq[2], rxq[1], rxq[0]};
          m_wrpend = 1;
          rxq.delete();
        end
      end
      m_start_prev = ccr_old[1];
      m_ccr        = usb_ccr_nxt_i;
    end
  end

  // Single compare process: outputs are register-driven, so negedge is safe.
  always @(negedge clk) begin
    if (chk_on) begin
      check("sta", {30'd0, usb_sta_o}, {30'd0, m_full, (m_loading || txq.size() != 0)});
      check("tx_valid", tx_valid_o, m_ccr[0] && txq.size() != 0);
      if (m_ccr[0] && txq.size() != 0) check("tx_data", tx_data_o, txq[0]);
      check("rx_ready", rx_ready_o, m_ccr[0] && m_ccr[2] && !m_full && !m_wrpend);
      check("write", write_perip, m_wrpend);
      if (m_wrpend) check("wdata", data_i_perip, m_word);
      check("rdaddr", rdaddr_perip, 32'h8);
      check("wraddr", wraddr_perip, 32'h4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    usb_sta_1_i = env_reg3;
    fw_ack      = 0;
  endtask

  logic [7:0] rb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] txb [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [7:0] got_tx [$];

  initial begin
    int idx, hs, got, t;
    rst_i = 1; usb_ccr_nxt_i = 0; usb_sta_1_i = 0; data_o_perip = 0;
    tx_ready_i = 0; rx_data_i = 0; rx_valid_i = 0; fw_ack = 0;
    tick();
    chk_on = 1;
    tick();
    // Reset state
    check("rst_sta", usb_sta_o, 2'b00);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_write", write_perip, 0);
    check("rst_rx_ready", rx_ready_o, 0);
    check("rst_wdata", data_i_perip, 0);
    rst_i = 0;
    tick();

    // 1: full-rate transmit, first valid three cycles after the start write
    data_o_perip = 32'hA1B2C3D4; tx_ready_i = 1; usb_ccr_nxt_i = 3'b011;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", tx_valid_o, 1);
      check("t1_byte", tx_data_o, txb[i]);
      check("t1_busy", usb_sta_o[0], 1);
      tick();
    end
    check("t1_done_valid", tx_valid_o, 0);
    check("t1_done_busy", usb_sta_o[0], 0);
    usb_ccr_nxt_i = 3'b001; tick();

    // 2: stalled transmit, ready toggling
    got_tx.delete();
    usb_ccr_nxt_i = 3'b011;
    for (int i = 0; i < 40 && got_tx.size() < 4; i++) begin
      tx_ready_i = i[0];
      if (tx_valid_o && tx_ready_i) got_tx.push_back(tx_data_o);
      tick();
    end
    check("t2_count", got_tx.size(), 4);
    for (int i = 0; i < got_tx.size(); i++) check("t2_byte", got_tx[i], txb[i]);
    usb_ccr_nxt_i = 3'b001; tx_ready_i = 1; tick(); tick();

    // 3: receive one word
    usb_ccr_nxt_i = 3'b101; tick();
    idx = 0;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      rx_valid_i = 1; rx_data_i = rb[idx];
      got = rx_ready_o;
      tick();
      if (got != 0) idx++;
    end
    rx_valid_i = 0;
    check("t3_taken", idx, 4);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (write_perip) begin
        check("t3_wdata", data_i_perip, 32'h44332211);
        check("t3_model_word", m_word, 32'h44332211);
        check("t3_wraddr", wraddr_perip, 32'h4);
        got = 1;
        break;
      end
      tick();
    end
    check("t3_write_seen", got, 1);
    tick();
    check("t3_sta1", usb_sta_o[1], 1);
    check("t3_ready", rx_ready_o, 0);

    // 4: fifth byte held off until acknowledge
    rx_valid_i = 1; rx_data_i = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("t4_blocked", rx_ready_o, 0);
      tick();
    end
    fw_ack = 1; tick();
    t = 0;
    while (usb_sta_o[1] && t < 10) begin tick(); t++; end
    check("t4_sta1_clear", usb_sta_o[1], 0);
    check("t4_accept", rx_ready_o, 1);
    tick();
    rx_valid_i = 0; tick();

    // 5: disable after two TX bytes, start bit held
    tx_ready_i = 1; usb_ccr_nxt_i = 3'b011;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid_o) hs++;
      if (hs == 2) break;
      tick();
    end
    check("t5_two_bytes", hs, 2);
    usb_ccr_nxt_i = 3'b010; tick();
    check("t5_valid_drop", tx_valid_o, 0);
    tick();
    check("t5_idle", usb_sta_o[0], 0);
    usb_ccr_nxt_i = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_retx", tx_valid_o, 0);
    end
    usb_ccr_nxt_i = 3'b001; tick();

    // 6: reset in the middle of a receive
    usb_ccr_nxt_i = 3'b101; tick();
    idx = 0;
    for (int i = 0; i < 10 && idx < 2; i++) begin
      rx_valid_i = 1; rx_data_i = 8'hE0 + 8'(idx);
      got = rx_ready_o;
      tick();
      if (got != 0) idx++;
    end
    rx_valid_i = 0;
    rst_i = 1; tick(); rst_i = 0;
    for (int i = 0; i < 6; i++) begin
      check("t6_no_write", write_perip, 0);
      tick();
    end

    // Randomized concurrent TX and RX traffic
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] c;
      c = usb_ccr_nxt_i;
      c[0] = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) c[1] = ~c[1];
      c[2] = ($urandom_range(0, 9) != 0);
      usb_ccr_nxt_i = c;
      data_o_perip  = $urandom;
      tx_ready_i    = ($urandom_range(0, 3) != 0);
      rx_valid_i    = ($urandom_range(0, 2) != 0);
      rx_data_i     = 8'($urandom);
      if (env_reg3 && $urandom_range(0, 5) == 0) fw_ack = 1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
